// File: rtl/ann_pkg.sv
// rtl/ann_pkg.sv - shared ANN datapath state enum and signed saturation limits
package ann_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } acc_state_t;

  localparam int unsigned SAT_MAX_W = 64;

  // Limits are returned at SAT_MAX_W bits; callers slice down to their width.
  function automatic logic signed [SAT_MAX_W-1:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [SAT_MAX_W-1:0] sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/sat_add_signed.sv
// rtl/sat_add_signed.sv - combinational W-bit signed saturating adder with overflow flag
module sat_add_signed
  import ann_pkg::*;
#(
  parameter int W = 32
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

  localparam logic signed [SAT_MAX_W-1:0] MAX_L = sat_max(W);
  localparam logic signed [SAT_MAX_W-1:0] MIN_L = sat_min(W);
  localparam logic signed [W-1:0]         MAX_V = MAX_L[W-1:0];
  localparam logic signed [W-1:0]         MIN_V = MIN_L[W-1:0];

  logic signed [W:0] full;

  assign full = {a[W-1], a} + {b[W-1], b};

  // The two top bits disagree only when the true sum left the W-bit range.
  always_comb begin
    sum = full[W-1:0];
    ovf = 1'b0;
    if (full[W] != full[W-1]) begin
      ovf = 1'b1;
      sum = full[W] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/acc_register.sv
// rtl/acc_register.sv - saturating N_TERMS accumulator with valid/ready I/O; ACC_REGISTER_RELU_EN clamps results at 0
module acc_register
  import ann_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 32,
  parameter int N_TERMS   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH-1:0]     d,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] q,
  output logic                        ovf
);

  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  acc_state_t                  state, state_n;
  logic signed [ACC_WIDTH-1:0] acc, acc_n;
  logic [CNT_W-1:0]            count, count_n;
  logic                        ovf_n;

  logic signed [ACC_WIDTH-1:0] d_ext, sum, result, final_val;
  logic                        add_ovf, accept, last_term;

  assign d_ext     = ACC_WIDTH'(d);
  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign q         = acc;
  assign accept    = in_valid & in_ready;

  sat_add_signed #(.W(ACC_WIDTH)) u_add (
    .a   (acc),
    .b   (d_ext),
    .sum (sum),
    .ovf (add_ovf)
  );

  assign last_term = ((state == IDLE) && (N_TERMS == 1)) ||
                     ((state == ACC) && (count == LAST_CNT));
  assign result    = (state == IDLE) ? d_ext : sum;

`ifdef ACC_REGISTER_RELU_EN
  assign final_val = (last_term && result < 0) ? '0 : result;
`else
  assign final_val = result;
`endif

  always_comb begin
    state_n = state;
    acc_n   = acc;
    count_n = count;
    ovf_n   = ovf;
    case (state)
      IDLE: begin
        if (accept) begin
          acc_n   = final_val;
          count_n = CNT_W'(1);
          ovf_n   = 1'b0;
          state_n = last_term ? HOLD : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          acc_n   = final_val;
          count_n = count + CNT_W'(1);
          ovf_n   = ovf | add_ovf;
          if (last_term) state_n = HOLD;
        end
      end
      HOLD: begin
        // ovf survives the handshake so the consumer can still read it.
        if (out_ready) begin
          state_n = IDLE;
          acc_n   = '0;
          count_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    if (clr) begin
      state_n = IDLE;
      acc_n   = '0;
      count_n = '0;
      ovf_n   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      count <= count_n;
      ovf   <= ovf_n;
    end
  end

endmodule

// File: tb/tb_acc_register.sv
// tb/tb_acc_register.sv - checks three acc_register builds against a behavioural model
module tb_acc_register;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // u0: 16/32/8, u1: 16/16/8, u2: 16/32/1
  logic              clr [3];
  logic              iv [3];
  logic              ordy [3];
  logic signed [15:0] dv [3];
  logic              irdy [3];
  logic              ov [3];
  logic              of [3];
  logic signed [31:0] q0, q2;
  logic signed [15:0] q1;

  int n_checks = 0;
  int n_fail = 0;

  acc_register #(.WIDTH(16), .ACC_WIDTH(32), .N_TERMS(8)) u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr[0]), .in_valid(iv[0]), .in_ready(irdy[0]),
    .d(dv[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .q(q0), .ovf(of[0]));
  acc_register #(.WIDTH(16), .ACC_WIDTH(16), .N_TERMS(8)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr[1]), .in_valid(iv[1]), .in_ready(irdy[1]),
    .d(dv[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .q(q1), .ovf(of[1]));
  acc_register #(.WIDTH(16), .ACC_WIDTH(32), .N_TERMS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .clr(clr[2]), .in_valid(iv[2]), .in_ready(irdy[2]),
    .d(dv[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .q(q2), .ovf(of[2]));

  function automatic longint get_q(input int i);
    case (i)
      0: return longint'(q0);
      1: return longint'(q1);
      default: return longint'(q2);
    endcase
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: running sum of the current result, terms taken, result waiting.
  int     nt [3] = '{8, 8, 1};
  int     aw [3] = '{32, 16, 32};
  longint m_sum [3];
  int     m_n [3];
  bit     m_ovf [3];
  bit     m_hold [3];

  task automatic model_step(input int i);
    longint mx, mn, s;
    mx = (longint'(1) <<< (aw[i] - 1)) - 1;
    mn = -(longint'(1) <<< (aw[i] - 1));
    if (clr[i]) begin
      m_sum[i] = 0; m_n[i] = 0; m_ovf[i] = 0; m_hold[i] = 0;
    end else if (m_hold[i]) begin
      if (ordy[i]) begin
        m_hold[i] = 0; m_sum[i] = 0; m_n[i] = 0;
      end
    end else if (iv[i]) begin
      if (m_n[i] == 0) begin
        s = longint'(dv[i]);
        m_ovf[i] = 0;
      end else begin
        s = m_sum[i] + longint'(dv[i]);
      end
      if (s > mx) begin s = mx; m_ovf[i] = 1; end
      if (s < mn) begin s = mn; m_ovf[i] = 1; end
      m_n[i]++;
      if (m_n[i] == nt[i]) begin
`ifdef ACC_REGISTER_RELU_EN
        if (s < 0) s = 0;
`endif
        m_hold[i] = 1;
      end
      m_sum[i] = s;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_sum[i] = 0; m_n[i] = 0; m_ovf[i] = 0; m_hold[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) model_step(i);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d in_ready", i), longint'(irdy[i]), longint'(!m_hold[i]));
        chk($sformatf("u%0d out_valid", i), longint'(ov[i]), longint'(m_hold[i]));
        chk($sformatf("u%0d q", i), get_q(i), m_sum[i]);
        chk($sformatf("u%0d ovf", i), longint'(of[i]), longint'(m_ovf[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input bit v, input int dval, input bit r);
    iv[i] = v;
    dv[i] = 16'(dval);
    ordy[i] = r;
  endtask

  task automatic feed(input int i, input int dval, input int n);
    for (int k = 0; k < n; k++) begin
      drive(i, 1'b1, dval, 1'b0);
      tick();
    end
    drive(i, 1'b0, 0, 1'b0);
  endtask

  task automatic consume(input int i);
    drive(i, 1'b0, 0, 1'b1);
    tick();
    drive(i, 1'b0, 0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      clr[i] = 1'b0;
      drive(i, 1'b0, 0, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset q", get_q(0), 0);
    chk("reset out_valid", longint'(ov[0]), 0);
    chk("reset in_ready", longint'(irdy[0]), 1);
    chk("reset ovf", longint'(of[0]), 0);

    // 1..8 back to back with out_ready held high
    for (int k = 1; k <= 8; k++) begin
      drive(0, 1'b1, k, 1'b1);
      tick();
      if (k == 7) chk("seq out_valid early", longint'(ov[0]), 0);
    end
    chk("seq out_valid", longint'(ov[0]), 1);
    chk("seq q", get_q(0), 36);
    chk("seq ovf", longint'(of[0]), 0);
    chk("seq in_ready hold", longint'(irdy[0]), 0);
    drive(0, 1'b0, 0, 1'b1);
    tick();
    chk("seq rearm", longint'(ov[0]), 0);
    drive(0, 1'b0, 0, 1'b0);

    // bubbles, then back-pressure while operands are offered
    for (int k = 1; k <= 8; k++) begin
      drive(0, 1'b1, k, 1'b0);
      tick();
      drive(0, 1'b0, 0, 1'b0);
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      drive(0, 1'b1, 100, 1'b0);
      tick();
      chk("stall q", get_q(0), 36);
      chk("stall out_valid", longint'(ov[0]), 1);
    end
    consume(0);

    // 16-bit accumulator saturation, then a clean result
    feed(1, 20000, 8);
    chk("sat q", get_q(1), 32767);
    chk("sat ovf", longint'(of[1]), 1);
    consume(1);
    chk("sat ovf retained", longint'(of[1]), 1);
    feed(1, 1, 8);
    chk("post-sat q", get_q(1), 8);
    chk("post-sat ovf", longint'(of[1]), 0);
    consume(1);

    // negative sum
    feed(0, -5, 8);
`ifdef ACC_REGISTER_RELU_EN
    chk("neg q", get_q(0), 0);
`else
    chk("neg q", get_q(0), -40);
`endif
    consume(0);

    // clr after three terms drops the operand offered alongside it
    feed(0, 9, 3);
    clr[0] = 1'b1;
    drive(0, 1'b1, 50, 1'b0);
    tick();
    clr[0] = 1'b0;
    drive(0, 1'b0, 0, 1'b0);
    chk("clr q", get_q(0), 0);
    feed(0, 2, 8);
    chk("post-clr q", get_q(0), 16);
    consume(0);

    // single-term build
    feed(2, -7, 1);
`ifdef ACC_REGISTER_RELU_EN
    chk("n1 q", get_q(2), 0);
`else
    chk("n1 q", get_q(2), -7);
`endif
    chk("n1 out_valid", longint'(ov[2]), 1);
    consume(2);

    // asynchronous reset while holding a result
    feed(0, 3, 8);
    chk("pre-reset q", get_q(0), 24);
    #2 rst_n = 1'b0;
    #1;
    chk("async q", get_q(0), 0);
    chk("async out_valid", longint'(ov[0]), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
